// File: rtl/uart_tx.sv
// UART transmitter: start bit, 1..8 data bits LSB first, optional parity, programmable stop.
// Framing settings are captured at acceptance so mid-frame changes cannot corrupt a frame.
module uart_tx #(
   parameter int DBIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      dbit,
   input  logic [1:0]      pbit,
   input  logic [7:0]      sb_tick,
   input  logic [7:0]      os_tick,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_done_tick,
   output logic            busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t          state_r;
   logic [7:0]      s_r;
   logic [2:0]      n_r;
   logic [DBIT-1:0] b_r;
   logic            par_r;
   logic [2:0]      last_r;
   logic            par_en_r;
   logic            par_odd_r;
   logic [7:0]      os_r;
   logic [7:0]      sb_r;
   logic            tx_r;
   logic            busy_r;
   logic            done_r;

   logic [7:0]      os_last_s;
   logic [7:0]      sb_last_s;

   // Index of the final data bit; 0 and anything above 8 mean a full byte.
   function automatic logic [2:0] last_index(input logic [3:0] d);
      logic [3:0] m;
      if ((d == 4'd0) || (d > 4'd8)) begin
         m = 4'd7;
      end else begin
         m = d - 4'd1;
      end
      return m[2:0];
   endfunction

   // Wrapping subtraction makes a setting of 0 behave as 256 ticks.
   assign os_last_s = os_r - 8'd1;
   assign sb_last_s = sb_r - 8'd1;

   assign tx           = tx_r;
   assign busy         = busy_r;
   assign tx_done_tick = done_r;

   // Frame sequencer with registered line, busy and done outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         s_r       <= 8'd0;
         n_r       <= 3'd0;
         b_r       <= '0;
         par_r     <= 1'b0;
         last_r    <= 3'd0;
         par_en_r  <= 1'b0;
         par_odd_r <= 1'b0;
         os_r      <= 8'd0;
         sb_r      <= 8'd0;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               tx_r   <= 1'b1;
               done_r <= 1'b0;
               // A request coinciding with the done pulse is dropped, not queued.
               if (tx_start && !done_r) begin
                  b_r       <= din;
                  last_r    <= last_index(dbit);
                  par_en_r  <= (pbit == 2'd1) || (pbit == 2'd2);
                  par_odd_r <= (pbit == 2'd2);
                  os_r      <= os_tick;
                  sb_r      <= sb_tick;
                  par_r     <= 1'b0;
                  s_r       <= 8'd0;
                  tx_r      <= 1'b0;
                  busy_r    <= 1'b1;
                  state_r   <= START;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_r == os_last_s) begin
                     s_r     <= 8'd0;
                     n_r     <= 3'd0;
                     tx_r    <= b_r[0];
                     state_r <= DATA;
                  end else begin
                     s_r <= s_r + 8'd1;
                  end
               end else begin
                  s_r <= s_r;
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_r == os_last_s) begin
                     s_r   <= 8'd0;
                     b_r   <= b_r >> 1;
                     par_r <= par_r ^ b_r[0];
                     if (n_r == last_r) begin
                        if (par_en_r) begin
                           tx_r    <= par_r ^ b_r[0] ^ par_odd_r;
                           state_r <= PARITY;
                        end else begin
                           tx_r    <= 1'b1;
                           state_r <= STOP;
                        end
                     end else begin
                        n_r  <= n_r + 3'd1;
                        tx_r <= b_r[1];
                     end
                  end else begin
                     s_r <= s_r + 8'd1;
                  end
               end else begin
                  s_r <= s_r;
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (s_r == os_last_s) begin
                     s_r     <= 8'd0;
                     tx_r    <= 1'b1;
                     state_r <= STOP;
                  end else begin
                     s_r <= s_r + 8'd1;
                  end
               end else begin
                  s_r <= s_r;
               end
            end
            STOP: begin
               tx_r <= 1'b1;
               // busy stays high through the done cycle and falls with the pulse.
               if (s_tick) begin
                  if (s_r == sb_last_s) begin
                     s_r     <= 8'd0;
                     done_r  <= 1'b1;
                     state_r <= IDLE;
                  end else begin
                     s_r <= s_r + 8'd1;
                  end
               end else begin
                  s_r <= s_r;
               end
            end
            default: begin
               state_r <= IDLE;
               s_r     <= 8'd0;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of framing vectors with hand-computed line patterns,
// plus sequences for reset abort, ignored requests, back-to-back frames and config isolation.
module tb_uart_tx;

   logic       clk;
   logic       reset;
   logic [3:0] dbit;
   logic [1:0] pbit;
   logic [7:0] sb_tick;
   logic [7:0] os_tick;
   logic       s_tick;
   logic       tx_start;
   logic [7:0] din;
   logic       tx;
   logic       tx_done_tick;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  dbit;
      logic [1:0]  pbit;
      logic [7:0]  os;
      logic [7:0]  sb;
      int          div;      // clk cycles per s_tick
      logic [7:0]  din;
      int          nb;       // line bits before stop (start + data + parity)
      logic [10:0] bits;     // bit i = expected line level of bit i
      int          bit_clks;
      int          stop_clks;
   } vec_t;

   vec_t vec [8];

   uart_tx #(.DBIT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .dbit        (dbit),
      .pbit        (pbit),
      .sb_tick     (sb_tick),
      .os_tick     (os_tick),
      .s_tick      (s_tick),
      .tx_start    (tx_start),
      .din         (din),
      .tx          (tx),
      .tx_done_tick(tx_done_tick),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic set_cfg_from(input int k);
      dbit    = vec[k].dbit;
      pbit    = vec[k].pbit;
      os_tick = vec[k].os;
      sb_tick = vec[k].sb;
   endtask

   // Called at a negedge with the DUT idle; returns one cycle after the done pulse.
   task automatic run_frame(input int k, input bit set_cfg, input bit poke_mid,
                            input bit chg_cfg, input int chg_k, input bit poke_done);
      int          e_done;
      int          bad_tx;
      int          first_bad;
      int          bad_busy;
      int          done_cnt;
      int          done_at;
      int          b;
      logic [10:0] pat;
      logic        exp_tx;
      bad_tx = 0; first_bad = -1; bad_busy = 0; done_cnt = 0; done_at = -1;
      b      = vec[k].bit_clks;
      pat    = vec[k].bits;
      e_done = vec[k].nb * b + vec[k].stop_clks;
      if (set_cfg) set_cfg_from(k);
      din      = vec[k].din;
      tx_start = 1'b1;
      s_tick   = 1'b0;
      @(negedge clk);
      for (int e = 0; e <= e_done; e++) begin
         exp_tx = (e < vec[k].nb * b) ? pat[e / b] : 1'b1;
         if (tx !== exp_tx) begin
            if (bad_tx == 0) first_bad = e;
            bad_tx++;
         end
         if (busy !== 1'b1) bad_busy++;
         if (tx_done_tick === 1'b1) begin
            done_cnt++;
            done_at = e;
         end
         s_tick   = (((e + 1) % vec[k].div) == 0);
         tx_start = 1'b0;
         if (poke_mid && (e == 2 * b + 3)) begin
            tx_start = 1'b1;
            din      = 8'hFF;
         end
         if (chg_cfg && (e == 3 * b)) set_cfg_from(chg_k);
         if (poke_done && (e == e_done)) tx_start = 1'b1;
         @(negedge clk);
      end
      s_tick = 1'b0;
      if (bad_tx != 0) $display("frame %0d first tx deviation at cycle %0d", k, first_bad);
      check($sformatf("frame%0d_tx_bad_cycles", k), bad_tx, 0);
      check($sformatf("frame%0d_busy_low_cycles", k), bad_busy, 0);
      check($sformatf("frame%0d_done_count", k), done_cnt, 1);
      check($sformatf("frame%0d_done_cycle", k), done_at, e_done);
      check($sformatf("frame%0d_busy_after", k), int'(busy), 0);
      check($sformatf("frame%0d_done_after", k), int'(tx_done_tick), 0);
      check($sformatf("frame%0d_tx_after", k), int'(tx), 1);
      tx_start = 1'b0;
   endtask

   initial begin
      int bad_idle;
      //          dbit   pbit  os      sb      div din    nb  bits      bclk stop
      vec[0] = '{4'd8,  2'd0, 8'd16,  8'd16,  1, 8'hA5, 9,  11'h14A, 16,  16};
      vec[1] = '{4'd7,  2'd1, 8'd16,  8'd16,  1, 8'h83, 9,  11'h006, 16,  16};
      vec[2] = '{4'd7,  2'd2, 8'd16,  8'd16,  1, 8'h83, 9,  11'h106, 16,  16};
      vec[3] = '{4'd8,  2'd2, 8'd32,  8'd64,  4, 8'h00, 10, 11'h200, 128, 256};
      vec[4] = '{4'd1,  2'd0, 8'd0,   8'd8,   1, 8'h01, 2,  11'h002, 256, 8};
      vec[5] = '{4'd0,  2'd3, 8'd4,   8'd4,   1, 8'h3C, 9,  11'h078, 4,   4};
      vec[6] = '{4'd12, 2'd1, 8'd2,   8'd3,   1, 8'hF1, 10, 11'h3E2, 2,   3};
      vec[7] = '{4'd5,  2'd0, 8'd3,   8'd2,   1, 8'hFF, 6,  11'h03E, 3,   2};

      reset = 1'b1; tx_start = 1'b0; s_tick = 1'b0; din = 8'h00;
      set_cfg_from(0);
      repeat (3) @(negedge clk);
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(tx_done_tick), 0);
      reset = 1'b0;
      @(negedge clk);

      // Abort mid-data with a reset between clock edges.
      din = 8'hA5; tx_start = 1'b1; s_tick = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (40) @(negedge clk);
      check("mid_frame_busy", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_tx", int'(tx), 1);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_done", int'(tx_done_tick), 0);
      @(negedge clk);
      reset  = 1'b0;
      s_tick = 1'b0;
      @(negedge clk);
      run_frame(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

      for (int k = 0; k < 8; k++) begin
         run_frame(k, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      end

      // Requests mid-frame and on the done cycle are dropped.
      run_frame(0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
      bad_idle = 0;
      for (int i = 0; i < 20; i++) begin
         if ((tx !== 1'b1) || (busy !== 1'b0)) bad_idle++;
         @(negedge clk);
      end
      check("no_queued_frame", bad_idle, 0);

      // Back-to-back: the next request lands the cycle after the done pulse.
      run_frame(2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      run_frame(1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

      // Config changed mid-frame applies only to the following frame.
      run_frame(0, 1'b1, 1'b0, 1'b1, 6, 1'b0);
      run_frame(6, 1'b0, 1'b0, 1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
